uart_receiver: RTL and testbench

- Receive half of the board UART, the counterpart of the transmitter already in the UART top level.
- Deserialises an asynchronous serial line `RxD` into bytes. Frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1).
- Bit rate is selected by `baud_select`; sampling is 16x oversampled.
- Reports each completed frame as valid data, a parity error or a framing error, for the same top level that hosts the transmitter.

---
 rtl/uart_receiver.sv | 156 +++++++++++++++
 tb/tb_uart_receiver.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Reports each frame as good data, a parity error and/or a framing error.
module uart_receiver #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  function automatic int div_of(input int baud);
    int d;
    d = (CLK_FREQ + 8 * baud) / (16 * baud);
    return (d < 1) ? 1 : d;
  endfunction

  localparam int D0 = div_of(300);
  localparam int D1 = div_of(1200);
  localparam int D2 = div_of(4800);
  localparam int D3 = div_of(9600);
  localparam int D4 = div_of(19200);
  localparam int D5 = div_of(38400);
  localparam int D6 = div_of(57600);
  localparam int D7 = div_of(115200);
  localparam int CW = $clog2(D0 + 1);

  // IDLE wait for 1->0 | START mid-bit check | DATA 8 bits | PARITY capture | STOP resolve
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rxs;
  logic [CW-1:0] div_sel;
  logic [CW-1:0] div_q;
  logic [CW-1:0] baud_cnt;
  logic          tick;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_q;
  logic          armed;
  logic          par_err;

  assign rxs     = sync[1];
  assign tick    = (baud_cnt == div_q - CW'(1));
  assign par_err = ^{shreg, parity_q};

  always_comb begin
    div_sel = CW'(D0);
    case (baud_select)
      3'b000: div_sel = CW'(D0);
      3'b001: div_sel = CW'(D1);
      3'b010: div_sel = CW'(D2);
      3'b011: div_sel = CW'(D3);
      3'b100: div_sel = CW'(D4);
      3'b101: div_sel = CW'(D5);
      3'b110: div_sel = CW'(D6);
      3'b111: div_sel = CW'(D7);
      default: div_sel = CW'(D0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], RxD};
  end

  always_ff @(posedge clk) begin
    if (reset || state == IDLE) baud_cnt <= '0;
    else if (tick)              baud_cnt <= '0;
    else                        baud_cnt <= baud_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_q     <= CW'(D0);
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      parity_q  <= 1'b0;
      armed     <= 1'b0;
      Rx_DATA   <= 8'h00;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      if (state != IDLE && !Rx_EN) begin
        state <= IDLE;
        armed <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // armed requires the line to be seen high first, so a held break cannot retrigger
            if (rxs) armed <= 1'b1;
            else if (Rx_EN && armed) begin
              state    <= START;
              armed    <= 1'b0;
              tick_cnt <= 4'd0;
              bit_cnt  <= 3'd0;
              div_q    <= div_sel;
            end
          end
          START: if (tick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= 4'd0;
              if (rxs) begin
                state <= IDLE;
                armed <= 1'b1;
              end else state <= DATA;
            end else tick_cnt <= tick_cnt + 4'd1;
          end
          DATA: if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shreg   <= {rxs, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
          end
          PARITY: if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              parity_q <= rxs;
              state    <= STOP;
            end
          end
          STOP: if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              Rx_FERROR <= ~rxs;
              Rx_PERROR <= par_err;
              if (rxs && !par_err) begin
                Rx_DATA  <= shreg;
                Rx_VALID <= 1'b1;
              end
              armed <= rxs;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver; CLK_FREQ is scaled down so code 111 gives
// 16 clk/bit and code 000 gives 3200 clk/bit.
module tb_uart_receiver;

  localparam int CLK_FREQ = 960000;
  localparam int BIT_FAST = 16;
  localparam int BIT_SLOW = 3200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic [2:0] baud_select = 3'b111;
  logic       Rx_EN = 1'b0;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

  // event word: {valid, perror, ferror, data}
  typedef logic [10:0] ev_t;
  ev_t exp_q[$];
  ev_t obs_q[$];
  int  vectors = 0;
  int  miscompares = 0;

  uart_receiver #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk), .reset(reset), .RxD(RxD), .baud_select(baud_select), .Rx_EN(Rx_EN),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (Rx_VALID || Rx_PERROR || Rx_FERROR)
      obs_q.push_back({Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_DATA});

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int n);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      RxD = bits[i];
      repeat (n) @(negedge clk);
    end
    RxD = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    vectors++; if (Rx_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h need 00", Rx_DATA); end
    vectors++; if (Rx_VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b need 0", Rx_VALID); end
    vectors++; if (Rx_PERROR !== 1'b0) begin miscompares++; $display("FAIL reset_perror: got %b need 0", Rx_PERROR); end
    vectors++; if (Rx_FERROR !== 1'b0) begin miscompares++; $display("FAIL reset_ferror: got %b need 0", Rx_FERROR); end
    reset = 1'b0;
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_good_frame();
    ev_t e, o;
    exp_q.push_back({3'b100, 8'hA5});
    send_frame(8'hA5, ^8'hA5, 1'b1, BIT_FAST);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL good_frame: got nothing need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL good_frame: got %h need %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL good_frame_extra: got %0d extra events need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_errors();
    ev_t e, o;
    exp_q.push_back({3'b010, 8'hA5});
    send_frame(8'h01, 1'b0, 1'b1, BIT_FAST);
    repeat (20) @(negedge clk);
    exp_q.push_back({3'b001, 8'hA5});
    send_frame(8'h3C, ^8'h3C, 1'b0, BIT_FAST);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL errors: got nothing need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL errors: got %h need %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL errors_extra: got %0d extra events need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_glitch();
    ev_t e, o;
    RxD = 1'b0;
    repeat (7) @(negedge clk);
    RxD = 1'b1;
    repeat (40) @(negedge clk);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL glitch: got %0d events need 0", obs_q.size()); obs_q.delete(); end
    exp_q.push_back({3'b100, 8'h7E});
    send_frame(8'h7E, ^8'h7E, 1'b1, BIT_FAST);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL after_glitch: got nothing need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL after_glitch: got %h need %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL after_glitch_extra: got %0d extra events need 0", obs_q.size()); obs_q.delete(); end
  endtask

  // Rate switches mid-frame: the slow frame keeps its latched rate, the
  // immediately following frame picks up the new fast rate.
  task automatic test_back_to_back();
    ev_t e, o;
    baud_select = 3'b000;
    repeat (4) @(negedge clk);
    exp_q.push_back({3'b100, 8'h55});
    exp_q.push_back({3'b100, 8'hAA});
    fork
      begin repeat (1000) @(negedge clk); baud_select = 3'b111; end
    join_none
    send_frame(8'h55, ^8'h55, 1'b1, BIT_SLOW);
    send_frame(8'hAA, ^8'hAA, 1'b1, BIT_FAST);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL back_to_back: got nothing need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL back_to_back: got %h need %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL back_to_back_extra: got %0d extra events need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_abort();
    ev_t e, o;
    Rx_EN = 1'b0;
    send_frame(8'h99, ^8'h99, 1'b1, BIT_FAST);
    repeat (10) @(negedge clk);
    Rx_EN = 1'b1;
    repeat (4) @(negedge clk);
    fork
      begin repeat (84) @(negedge clk); Rx_EN = 1'b0; end
    join_none
    send_frame(8'hC3, ^8'hC3, 1'b1, BIT_FAST);
    repeat (4) @(negedge clk);
    Rx_EN = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL en_abort: got %0d events need 0", obs_q.size()); obs_q.delete(); end
    vectors++; if (Rx_DATA !== 8'hAA) begin miscompares++; $display("FAIL en_abort_data: got %h need aa", Rx_DATA); end
    fork
      begin repeat (60) @(negedge clk); reset = 1'b1; end
    join_none
    send_frame(8'hC3, ^8'hC3, 1'b1, BIT_FAST);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL reset_abort: got %0d events need 0", obs_q.size()); obs_q.delete(); end
    vectors++; if (Rx_DATA !== 8'h00) begin miscompares++; $display("FAIL reset_abort_data: got %h need 00", Rx_DATA); end
    exp_q.push_back({3'b100, 8'h5A});
    send_frame(8'h5A, ^8'h5A, 1'b1, BIT_FAST);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL after_reset: got nothing need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL after_reset: got %h need %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL after_reset_extra: got %0d extra events need 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_break();
    ev_t e, o;
    exp_q.push_back({3'b001, 8'h5A});
    RxD = 1'b0;
    repeat (20 * BIT_FAST) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * BIT_FAST) @(negedge clk);
    exp_q.push_back({3'b100, 8'h0F});
    send_frame(8'h0F, ^8'h0F, 1'b1, BIT_FAST);
    repeat (20) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (obs_q.size() == 0) begin miscompares++; $display("FAIL break: got nothing need %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin miscompares++; $display("FAIL break: got %h need %h", o, e); end end
    end
    vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL break_extra: got %0d extra events need 0", obs_q.size()); obs_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_errors();
    test_glitch();
    test_back_to_back();
    test_abort();
    test_break();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
